// File: rtl/power_gate_sequencer.sv
// ----------------------------------------------------------------------------
// power_gate_sequencer
//
// Power/clock gating sequencer for a downstream gated counter. A four-state
// Moore FSM (OFF, PWR_UP, ON, GATED) raises power first, then the clock after
// a fixed power-up delay. After a run of idle cycles it gates the clock, and
// after a further run of idle cycles it removes power. While the clock is
// gated, new work restores the clock immediately without a power-up delay.
//
// Parameters
//   PWR_UP_CYCLES : cycles power_enable is high before enable_clk rises (1..255)
//   IDLE_CYCLES   : consecutive idle cycles in ON before gating the clock (1..255)
//   SLEEP_CYCLES  : consecutive idle cycles in GATED before power-off (1..255)
//
// Ports
//   clk          : single clock, rising-edge
//   rst          : synchronous, active-high reset
//   activity     : work pending for the downstream counter
//   force_on     : software hold; wakes the domain and keeps it in ON
//   power_enable : power-gating control for the downstream counter
//   enable_clk   : clock-gating control for the downstream counter
//   ready        : high only in state ON
//   state        : current state, OFF=0 PWR_UP=1 ON=2 GATED=3
// ----------------------------------------------------------------------------
module power_gate_sequencer #(
    parameter int PWR_UP_CYCLES = 4,
    parameter int IDLE_CYCLES   = 16,
    parameter int SLEEP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       activity,
    input  logic       force_on,
    output logic       power_enable,
    output logic       enable_clk,
    output logic       ready,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_PWR_UP = 2'd1,
        ST_ON     = 2'd2,
        ST_GATED  = 2'd3
    } state_e;

    // Terminal values for the 8-bit counters.
    localparam logic [7:0] PWR_LOAD   = 8'(PWR_UP_CYCLES - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] SLEEP_LAST = 8'(SLEEP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] pwr_cnt_q, pwr_cnt_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       wake;

    assign wake = activity | force_on;

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        idle_cnt_d = idle_cnt_q;

        case (state_q)
            ST_OFF: begin
                if (wake) begin
                    state_d   = ST_PWR_UP;
                    pwr_cnt_d = PWR_LOAD;
                end
            end

            // Wake is ignored here: a started power-up always completes.
            // The count is loaded on entry, so reading 0 ends the phase
            // after exactly PWR_UP_CYCLES cycles.
            ST_PWR_UP: begin
                if (pwr_cnt_q == '0) begin
                    state_d    = ST_ON;
                    idle_cnt_d = '0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q - 8'd1;
                end
            end

            // Wake is tested first so it wins over a coincident terminal
            // count; the counter then restarts instead of gating.
            ST_ON: begin
                if (wake) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end

            // Fast wake straight back to ON: power is still up.
            ST_GATED: begin
                if (wake) begin
                    state_d    = ST_ON;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == SLEEP_LAST) begin
                    state_d    = ST_OFF;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d    = ST_OFF;
                pwr_cnt_d  = '0;
                idle_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            pwr_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode: from the state register only
    // ------------------------------------------------------------------------
    always_comb begin
        power_enable = 1'b0;
        enable_clk   = 1'b0;
        ready        = 1'b0;
        case (state_q)
            ST_OFF: begin
                power_enable = 1'b0;
                enable_clk   = 1'b0;
            end
            ST_PWR_UP: begin
                power_enable = 1'b1;
                enable_clk   = 1'b0;
            end
            ST_ON: begin
                power_enable = 1'b1;
                enable_clk   = 1'b1;
                ready        = 1'b1;
            end
            ST_GATED: begin
                power_enable = 1'b1;
                enable_clk   = 1'b0;
            end
            default: begin
                power_enable = 1'b0;
                enable_clk   = 1'b0;
                ready        = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_power_gate_sequencer.sv
// ----------------------------------------------------------------------------
// tb_power_gate_sequencer
//
// Directed bench for power_gate_sequencer with default parameters
// (PWR_UP_CYCLES=4, IDLE_CYCLES=16, SLEEP_CYCLES=8). Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point. Each scenario
// task checks {state, power_enable, enable_clk, ready} against the output
// table for the expected state.
// ----------------------------------------------------------------------------
module tb_power_gate_sequencer;

    logic       clk;
    logic       rst;
    logic       activity;
    logic       force_on;
    logic       power_enable;
    logic       enable_clk;
    logic       ready;
    logic [1:0] state;

    int vectors;
    int miscompares;

    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_PWR_UP = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_GATED  = 2'd3;

    power_gate_sequencer #(
        .PWR_UP_CYCLES(4),
        .IDLE_CYCLES  (16),
        .SLEEP_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .activity    (activity),
        .force_on    (force_on),
        .power_enable(power_enable),
        .enable_clk  (enable_clk),
        .ready       (ready),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state, pe, ec, ready} for a given state.
    function automatic logic [4:0] exp_of(input logic [1:0] st);
        case (st)
            2'd0:    return 5'b00_0_0_0;
            2'd1:    return 5'b01_1_0_0;
            2'd2:    return 5'b10_1_1_1;
            default: return 5'b11_1_0_0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst = 1'b1; activity = 1'b0; force_on = 1'b0;
        tick(); tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_OFF)) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", obs, exp_of(S_OFF));
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {state, power_enable, enable_clk, ready};
            vectors++;
            if (obs !== exp_of(S_OFF)) begin
                miscompares++;
                $display("FAIL off_no_wake cyc %0d: got %b expected %b", i, obs, exp_of(S_OFF));
            end
        end
    endtask

    task automatic test_wake_from_off();
        logic [4:0] obs;
        activity = 1'b1;
        tick();
        activity = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs = {state, power_enable, enable_clk, ready};
            vectors++;
            if (obs !== exp_of(S_PWR_UP)) begin
                miscompares++;
                $display("FAIL wake_pwr_up cyc %0d: got %b expected %b", i, obs, exp_of(S_PWR_UP));
            end
            tick();
        end
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_ON)) begin
            miscompares++;
            $display("FAIL wake_on: got %b expected %b", obs, exp_of(S_ON));
        end
    endtask

    task automatic test_idle_gating();
        logic [4:0] obs;
        activity = 1'b1;
        tick();
        activity = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            obs = {state, power_enable, enable_clk, ready};
            vectors++;
            if (obs !== exp_of((i == 16) ? S_GATED : S_ON)) begin
                miscompares++;
                $display("FAIL idle_gating idle %0d: got %b expected %b", i, obs,
                         exp_of((i == 16) ? S_GATED : S_ON));
            end
        end
    endtask

    task automatic test_power_down();
        logic [4:0] obs;
        for (int i = 1; i <= 8; i++) begin
            tick();
            obs = {state, power_enable, enable_clk, ready};
            vectors++;
            if (obs !== exp_of((i == 8) ? S_OFF : S_GATED)) begin
                miscompares++;
                $display("FAIL power_down idle %0d: got %b expected %b", i, obs,
                         exp_of((i == 8) ? S_OFF : S_GATED));
            end
        end
    endtask

    task automatic test_fast_wake();
        logic [4:0] obs;
        // OFF -> PWR_UP -> ON -> GATED
        activity = 1'b1;
        tick();
        activity = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 1; i <= 16; i++) tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_GATED)) begin
            miscompares++;
            $display("FAIL fast_wake_setup: got %b expected %b", obs, exp_of(S_GATED));
        end
        for (int i = 1; i <= 4; i++) tick();
        activity = 1'b1;
        tick();
        activity = 1'b0;
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_ON)) begin
            miscompares++;
            $display("FAIL fast_wake_on: got %b expected %b", obs, exp_of(S_ON));
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            obs = {state, power_enable, enable_clk, ready};
            vectors++;
            if (obs !== exp_of((i == 16) ? S_GATED : S_ON)) begin
                miscompares++;
                $display("FAIL fast_wake_restart idle %0d: got %b expected %b", i, obs,
                         exp_of((i == 16) ? S_GATED : S_ON));
            end
        end
    endtask

    task automatic test_force_hold();
        logic [4:0] obs;
        int         bad;
        force_on = 1'b1;
        activity = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            obs = {state, power_enable, enable_clk, ready};
            if (obs !== exp_of(S_ON)) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL force_hold: %0d of 100 cycles left ON, required 0", bad);
        end
        force_on = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            obs = {state, power_enable, enable_clk, ready};
            vectors++;
            if (obs !== exp_of(S_ON)) begin
                miscompares++;
                $display("FAIL force_release idle %0d: got %b expected %b", i, obs, exp_of(S_ON));
            end
            tick();
        end
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_GATED)) begin
            miscompares++;
            $display("FAIL force_release_gate: got %b expected %b", obs, exp_of(S_GATED));
        end
    endtask

    task automatic test_wake_priority();
        logic [4:0] obs;
        // GATED at terminal count: wake must win over power-off
        for (int i = 1; i <= 7; i++) tick();
        activity = 1'b1;
        tick();
        activity = 1'b0;
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_ON)) begin
            miscompares++;
            $display("FAIL priority_gated: got %b expected %b", obs, exp_of(S_ON));
        end
        // ON at terminal count: wake must win over gating
        for (int i = 1; i <= 15; i++) tick();
        activity = 1'b1;
        tick();
        activity = 1'b0;
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_ON)) begin
            miscompares++;
            $display("FAIL priority_on: got %b expected %b", obs, exp_of(S_ON));
        end
        for (int i = 1; i <= 15; i++) tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_ON)) begin
            miscompares++;
            $display("FAIL priority_restart_15: got %b expected %b", obs, exp_of(S_ON));
        end
        tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_GATED)) begin
            miscompares++;
            $display("FAIL priority_restart_16: got %b expected %b", obs, exp_of(S_GATED));
        end
    endtask

    task automatic test_reset_mid_gated();
        logic [4:0] obs;
        for (int i = 1; i <= 3; i++) tick();
        rst = 1'b1;
        tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_OFF)) begin
            miscompares++;
            $display("FAIL reset_mid_gated: got %b expected %b", obs, exp_of(S_OFF));
        end
        rst = 1'b0;
        tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_OFF)) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b expected %b", obs, exp_of(S_OFF));
        end
    endtask

    task automatic test_reset_mid_pwrup();
        logic [4:0] obs;
        activity = 1'b1;
        tick();
        tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_PWR_UP)) begin
            miscompares++;
            $display("FAIL pwrup_cycle2: got %b expected %b", obs, exp_of(S_PWR_UP));
        end
        rst = 1'b1;
        tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_OFF)) begin
            miscompares++;
            $display("FAIL reset_mid_pwrup: got %b expected %b", obs, exp_of(S_OFF));
        end
        tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_OFF)) begin
            miscompares++;
            $display("FAIL reset_held_wake: got %b expected %b", obs, exp_of(S_OFF));
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {state, power_enable, enable_clk, ready};
            vectors++;
            if (obs !== exp_of(S_PWR_UP)) begin
                miscompares++;
                $display("FAIL pwrup_restart cyc %0d: got %b expected %b", i, obs, exp_of(S_PWR_UP));
            end
        end
        tick();
        obs = {state, power_enable, enable_clk, ready};
        vectors++;
        if (obs !== exp_of(S_ON)) begin
            miscompares++;
            $display("FAIL pwrup_restart_on: got %b expected %b", obs, exp_of(S_ON));
        end
        activity = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        activity    = 1'b0;
        force_on    = 1'b0;

        test_reset();
        test_wake_from_off();
        test_idle_gating();
        test_power_down();
        test_fast_wake();
        test_force_hold();
        test_wake_priority();
        test_reset_mid_gated();
        test_reset_mid_pwrup();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/power_gate_sequencer.md
POWER_GATE_SEQUENCER -- requirements
Module: power_gate_sequencer

Interface
REQ-001 The block SHALL have parameter PWR_UP_CYCLES, default 4: cycles power_enable is high before enable_clk rises; legal range 1..255.
REQ-002 The block SHALL have parameter IDLE_CYCLES, default 16: consecutive idle cycles in ON before the clock is gated; legal range 1..255.
REQ-003 The block SHALL have parameter SLEEP_CYCLES, default 8: consecutive idle cycles in GATED before power is removed; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port activity, input, 1 bit: work pending for the downstream gated counter.
REQ-007 The block SHALL have port force_on, input, 1 bit: software hold; while high the domain is woken and kept in ON.
REQ-008 The block SHALL have port power_enable, output, 1 bit: drives the downstream counter's power-gating input.
REQ-009 The block SHALL have port enable_clk, output, 1 bit: drives the downstream counter's clock-gating input.
REQ-010 The block SHALL have port ready, output, 1 bit: high only in state ON.
REQ-011 The block SHALL have port state, output, 2 bits: current state encoding OFF=0, PWR_UP=1, ON=2, GATED=3.

Function
REQ-012 The block SHALL be a Moore FSM; power_enable, enable_clk, ready and state SHALL be decoded from the state register only, with no combinational path from inputs.
REQ-013 The block SHALL drive outputs per state: OFF pe=0 ec=0; PWR_UP pe=1 ec=0; ON pe=1 ec=1; GATED pe=1 ec=0.
REQ-014 The block SHALL define wake as (activity | force_on) sampled on a rising edge.
REQ-015 In OFF, the block SHALL move to PWR_UP on the next edge if wake=1, else remain in OFF.
REQ-016 On entry to PWR_UP, the block SHALL load an 8-bit down-counter with PWR_UP_CYCLES-1, decrement it each cycle, and move to ON on the edge after it reads 0, so PWR_UP lasts exactly PWR_UP_CYCLES cycles.
REQ-017 In PWR_UP, the block SHALL ignore wake; power-up is never aborted except by rst.
REQ-018 On entry to ON, the block SHALL clear an 8-bit idle counter; in ON, wake=1 SHALL clear it, and wake=0 SHALL increment it.
REQ-019 In ON, the block SHALL move to GATED when wake=0 and the idle counter equals IDLE_CYCLES-1, i.e. after exactly IDLE_CYCLES consecutive idle cycles.
REQ-020 On entry to GATED, the block SHALL clear the idle counter; in GATED, wake=0 SHALL increment it.
REQ-021 In GATED, wake=1 SHALL cause a move to ON on the next edge (fast wake, no PWR_UP delay).
REQ-022 In GATED, the block SHALL move to OFF when wake=0 and the idle counter equals SLEEP_CYCLES-1.
REQ-023 The block SHALL stay in ON while force_on=1 regardless of activity.
REQ-024 Counters SHALL never wrap; the transition conditions bound them below 255.
REQ-025 When wake=1 and the idle terminal count coincide in ON or GATED, the block SHALL give wake priority: the counter clears and no down-transition occurs.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL enter OFF and clear both counters, so the outputs after that edge are pe=0, ec=0, ready=0, state=0.
REQ-027 rst SHALL take priority over every transition, including mid-PWR_UP and mid-GATED; the domain SHALL drop power on the edge after rst is sampled.
REQ-028 The block SHALL resume operation on the first edge at which rst=0, evaluating wake in OFF.

Verification
REQ-029 Bench SHALL cover wake from OFF (defaults): activity=1 for one cycle at edge N -> pe=1 from N+1, ec=1 and ready=1 from N+5, state 0->1->2.
REQ-030 Bench SHALL cover idle gating: in ON, activity=0 held -> state=3 and ec=0 exactly 16 cycles after the last active edge, pe still 1.
REQ-031 Bench SHALL cover full power-down: continuing idle in GATED -> state=0 and pe=0 after 8 further idle cycles.
REQ-032 Bench SHALL cover fast wake: activity=1 in GATED on the 5th idle cycle -> state=2 and ec=1 on the next edge, and the idle counter restarts.
REQ-033 Bench SHALL cover force hold: force_on=1 with activity=0 for 100 cycles in ON -> state stays 2; on force_on release, state=3 after 16 cycles.
REQ-034 Bench SHALL cover reset mid-operation: rst=1 during cycle 2 of PWR_UP -> pe=0 and state=0 on the next edge; with activity held high during rst, the PWR_UP sequence restarts after rst falls.
